div_unit: RTL

//   Iterative radix-2 RV64M divide/remainder unit for the EX stage, beside the combinational ALU.
//   - Takes two 64-bit operands and a 3-bit div_op.
//   - Performs one restoring-division step per clock.
//   - Returns a sign-corrected 64-bit result with a one-cycle done pulse.
//   - Raises busy so the pipeline control stalls while a divide is in flight.

---
 rtl/div_unit.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divide/remainder unit (RV64M DIV/REM and W variants).
// Optional DIV_SPECIAL_FASTPATH_EN: divide-by-zero and signed overflow skip the iterations.
module div_unit #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic [2:0]      div_op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            ready,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] res
);

    localparam int HALF = XLEN / 2;
    localparam int CW   = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [XLEN-1:0] dend_q, dend_d;
    logic            is_w_q, is_w_d;
    logic            is_rem_q, is_rem_d;
    logic            qneg_q, qneg_d;
    logic            rneg_q, rneg_d;
    logic            dz_q, dz_d;
    logic            ovf_q, ovf_d;
    logic            done_q, done_d;
    logic [XLEN-1:0] res_q, res_d;

    // Operand preparation at accept
    logic            op_w, op_rem, op_uns;
    logic [XLEN-1:0] a_ext, b_ext, a_abs, b_abs, a_dend;
    logic            sa, sb, acc_dz, acc_ovf;

    always_comb begin
        op_w   = div_op[2];
        op_rem = div_op[1];
        op_uns = div_op[0];
        if (op_w) begin
            a_ext = op_uns ? {{HALF{1'b0}}, a[HALF-1:0]} : {{HALF{a[HALF-1]}}, a[HALF-1:0]};
            b_ext = op_uns ? {{HALF{1'b0}}, b[HALF-1:0]} : {{HALF{b[HALF-1]}}, b[HALF-1:0]};
            a_dend = {{HALF{a[HALF-1]}}, a[HALF-1:0]};
            acc_ovf = !op_uns && (a[HALF-1:0] == {1'b1, {(HALF-1){1'b0}}}) && (b[HALF-1:0] == '1);
        end else begin
            a_ext  = a;
            b_ext  = b;
            a_dend = a;
            acc_ovf = !op_uns && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
        end
        sa     = !op_uns && a_ext[XLEN-1];
        sb     = !op_uns && b_ext[XLEN-1];
        a_abs  = sa ? (~a_ext + 1'b1) : a_ext;
        b_abs  = sb ? (~b_ext + 1'b1) : b_ext;
        acc_dz = (b_ext == '0);
    end

    // One restoring step: the shifted-in dividend bit comes from the top of quo_q
    logic [XLEN:0] trial;
    logic          step_ge;

    always_comb begin
        trial   = {rem_q, quo_q[XLEN-1]};
        step_ge = (trial >= {1'b0, dvs_q});
    end

    // Sign fixup and special-case substitution
    logic [XLEN-1:0] mag_q, sq, sr, pick;

    always_comb begin
        mag_q = is_w_q ? {{HALF{1'b0}}, quo_q[HALF-1:0]} : quo_q;
        sq    = qneg_q ? (~mag_q + 1'b1) : mag_q;
        sr    = rneg_q ? (~rem_q + 1'b1) : rem_q;
        pick  = is_rem_q ? sr : sq;
        if (dz_q) begin
            pick = is_rem_q ? dend_q : '1;
        end else if (ovf_q) begin
            pick = is_rem_q ? '0 : dend_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        dend_d   = dend_q;
        is_w_d   = is_w_q;
        is_rem_d = is_rem_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        dz_d     = dz_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        res_d    = res_q;
        unique case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    is_w_d   = op_w;
                    is_rem_d = op_rem;
                    qneg_d   = sa ^ sb;
                    rneg_d   = sa;
                    dz_d     = acc_dz;
                    ovf_d    = acc_ovf;
                    dend_d   = a_dend;
                    dvs_d    = b_abs;
                    rem_d    = '0;
                    quo_d    = op_w ? {a_abs[HALF-1:0], {HALF{1'b0}}} : a_abs;
                    cnt_d    = op_w ? CW'(HALF) : CW'(XLEN);
`ifdef DIV_SPECIAL_FASTPATH_EN
                    state_d  = (acc_dz || acc_ovf) ? FIN : CALC;
`else
                    state_d  = CALC;
`endif
                end
            end
            CALC: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    rem_d = step_ge ? XLEN'(trial - {1'b0, dvs_q}) : trial[XLEN-1:0];
                    quo_d = {quo_q[XLEN-2:0], step_ge};
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        state_d = FIN;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
                if (!flush) begin
                    done_d = 1'b1;
                    res_d  = is_w_q ? {{HALF{pick[HALF-1]}}, pick[HALF-1:0]} : pick;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            dend_q   <= '0;
            is_w_q   <= 1'b0;
            is_rem_q <= 1'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            dend_q   <= dend_d;
            is_w_q   <= is_w_d;
            is_rem_q <= is_rem_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            dz_q     <= dz_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
            res_q    <= res_d;
        end
    end

    assign ready = (state_q == IDLE);
    assign busy  = (state_q != IDLE);
    assign done  = done_q;
    assign res   = res_q;

endmodule
